// File: rtl/ppr_mem_pkg.sv
// Shared types for the score-RAM access path: FSM states, request record, channel ids.
// No logic; reset/latency/backpressure not applicable.
// Request record widths match the default conflict-detector address/data widths.
package ppr_mem_pkg;

  localparam int PPR_ADDR_WIDTH = 13;
  localparam int PPR_DATA_WIDTH = 32;

  typedef enum logic {ST_IDLE, ST_DRAIN} state_t;

  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

  typedef struct packed {
    logic                      we;
    logic [PPR_ADDR_WIDTH-1:0] addr;
    logic [PPR_DATA_WIDTH-1:0] wdata;
  } req_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for statistics; holds at all-ones instead of wrapping.
// Latency: count updates on the edge after inc is sampled high.
// Backpressure: none; clr_n is a synchronous active-low clear.
module sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 clr_n,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bank_access_arbiter.sv
// Issues channel A on RAM port 0 and B on port 1; colliding pairs are serialized round-robin.
// Latency: 1 cycle acceptance-to-issue; a serialized loser issues after 2 cycles.
// Backpressure: both readies drop for the single DRAIN cycle following a collision.
module bank_access_arbiter
  import ppr_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = PPR_ADDR_WIDTH,
  parameter int DATA_WIDTH = PPR_DATA_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic                  a_we,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic                  b_we,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  input  logic                  conflict,
  output logic                  m0_en,
  output logic                  m0_we,
  output logic [ADDR_WIDTH-1:0] m0_addr,
  output logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m1_en,
  output logic                  m1_we,
  output logic [ADDR_WIDTH-1:0] m1_addr,
  output logic [DATA_WIDTH-1:0] m1_wdata,
  output logic [CNT_WIDTH-1:0]  conflict_cnt
);

  // Local record sized by this instance's parameters rather than the package defaults.
  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } chan_req_t;

  state_t    state, state_nxt;
  logic      rr, rr_nxt;
  chan_req_t pend, pend_nxt;
  chan_req_t m0_q, m0_nxt, m1_q, m1_nxt;
  logic      m0_en_q, m0_en_nxt, m1_en_q, m1_en_nxt;
  logic      cnt_inc;
  chan_req_t a_req, b_req;

  assign a_req = {a_we, a_addr, a_wdata};
  assign b_req = {b_we, b_addr, b_wdata};

  assign a_ready = (state == ST_IDLE);
  assign b_ready = (state == ST_IDLE);

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr;
    pend_nxt  = pend;
    m0_en_nxt = 1'b0;
    m1_en_nxt = 1'b0;
    m0_nxt    = '0;
    m1_nxt    = '0;
    cnt_inc   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (a_valid && b_valid && conflict) begin
          if (rr == CH_A) begin
            m0_en_nxt = 1'b1;
            m0_nxt    = a_req;
            pend_nxt  = b_req;
          end else begin
            m1_en_nxt = 1'b1;
            m1_nxt    = b_req;
            pend_nxt  = a_req;
          end
          rr_nxt    = ~rr;
          cnt_inc   = 1'b1;
          state_nxt = ST_DRAIN;
        end else begin
          m0_en_nxt = a_valid;
          m1_en_nxt = b_valid;
          if (a_valid) m0_nxt = a_req;
          if (b_valid) m1_nxt = b_req;
        end
      end
      ST_DRAIN: begin
        // rr has already toggled, so it now names the loser and thus its port.
        if (rr == CH_B) begin
          m1_en_nxt = 1'b1;
          m1_nxt    = pend;
        end else begin
          m0_en_nxt = 1'b1;
          m0_nxt    = pend;
        end
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      rr      <= CH_A;
      pend    <= '0;
      m0_en_q <= 1'b0;
      m1_en_q <= 1'b0;
      m0_q    <= '0;
      m1_q    <= '0;
    end else begin
      state   <= state_nxt;
      rr      <= rr_nxt;
      pend    <= pend_nxt;
      m0_en_q <= m0_en_nxt;
      m1_en_q <= m1_en_nxt;
      m0_q    <= m0_nxt;
      m1_q    <= m1_nxt;
    end
  end

  assign m0_en    = m0_en_q;
  assign m0_we    = m0_q.we;
  assign m0_addr  = m0_q.addr;
  assign m0_wdata = m0_q.wdata;
  assign m1_en    = m1_en_q;
  assign m1_we    = m1_q.we;
  assign m1_addr  = m1_q.addr;
  assign m1_wdata = m1_q.wdata;

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_conflict_cnt (
    .clk   (clk),
    .clr_n (rst_n),
    .inc   (cnt_inc),
    .cnt   (conflict_cnt)
  );

endmodule

// File: tb/tb_bank_access_arbiter.sv
// Directed bench for bank_access_arbiter: vector table plus reset and saturation sequences.
module tb_bank_access_arbiter;

  localparam int AW = 13;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_valid, b_valid, a_ready, b_ready, a_we, b_we, conflict;
  logic [AW-1:0] a_addr, b_addr, m0_addr, m1_addr;
  logic [DW-1:0] a_wdata, b_wdata, m0_wdata, m1_wdata;
  logic          m0_en, m0_we, m1_en, m1_we;
  logic [CW-1:0] conflict_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bank_access_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_we(a_we), .a_wdata(a_wdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_we(b_we), .b_wdata(b_wdata),
    .conflict(conflict),
    .m0_en(m0_en), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_en(m1_en), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .conflict_cnt(conflict_cnt)
  );

  typedef struct {
    logic av, bv, awe, bwe;
    logic [AW-1:0] aaddr, baddr;
    logic [DW-1:0] awd, bwd;
    logic cf;
    logic e0en, e0we; logic [AW-1:0] e0addr; logic [DW-1:0] e0wd;
    logic e1en, e1we; logic [AW-1:0] e1addr; logic [DW-1:0] e1wd;
    logic erdy; logic [CW-1:0] ecnt;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic bv, input logic awe, input logic bwe,
                       input logic [AW-1:0] aa, input logic [AW-1:0] ba,
                       input logic [DW-1:0] awd, input logic [DW-1:0] bwd, input logic cf);
    a_valid = av; b_valid = bv; a_we = awe; b_we = bwe;
    a_addr = aa; b_addr = ba; a_wdata = awd; b_wdata = bwd; conflict = cf;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0] = '{1,1,1,0,13'h010,13'h1F00,32'hAAAA,32'h0,0, 1,1,13'h010,32'hAAAA, 1,0,13'h1F00,32'h0, 1,4'd0};
    tbl[1] = '{1,1,0,1,13'h001,13'h002,32'h11,32'h22,1,   1,0,13'h001,32'h11,   0,0,13'h0,32'h0,     0,4'd1};
    tbl[2] = '{1,1,0,1,13'h001,13'h002,32'h11,32'h22,1,   0,0,13'h0,32'h0,      1,1,13'h002,32'h22,  1,4'd1};
    tbl[3] = '{1,1,0,1,13'h001,13'h002,32'h11,32'h22,1,   0,0,13'h0,32'h0,      1,1,13'h002,32'h22,  0,4'd2};
    tbl[4] = '{1,1,0,1,13'h001,13'h002,32'h11,32'h22,1,   1,0,13'h001,32'h11,   0,0,13'h0,32'h0,     1,4'd2};
    tbl[5] = '{0,1,0,0,13'h0,13'h0AB,32'h0,32'h0,1,       0,0,13'h0,32'h0,      1,0,13'h0AB,32'h0,   1,4'd2};
    tbl[6] = '{1,0,1,0,13'h055,13'h0,32'h5,32'h0,1,       1,1,13'h055,32'h5,    0,0,13'h0,32'h0,     1,4'd2};
    tbl[7] = '{0,0,0,0,13'h0,13'h0,32'h0,32'h0,1,         0,0,13'h0,32'h0,      0,0,13'h0,32'h0,     1,4'd2};
    tbl[8] = '{1,1,1,1,13'h100,13'h100,32'h1,32'h2,1,     1,1,13'h100,32'h1,    0,0,13'h0,32'h0,     0,4'd3};
    tbl[9] = '{0,0,0,0,13'h0,13'h0,32'h0,32'h0,0,         0,0,13'h0,32'h0,      1,1,13'h100,32'h2,   1,4'd3};

    // Reset held two cycles with a colliding pair presented.
    rst_n = 1'b0;
    drive(1, 1, 1, 1, 13'h7, 13'h7, 32'hF, 32'hF, 1);
    tick(); tick();
    chk("rst_m0_en", m0_en, 0);   chk("rst_m1_en", m1_en, 0);
    chk("rst_m0_we", m0_we, 0);   chk("rst_m1_we", m1_we, 0);
    chk("rst_m0_addr", m0_addr, 0); chk("rst_m1_addr", m1_addr, 0);
    chk("rst_m0_wdata", m0_wdata, 0); chk("rst_m1_wdata", m1_wdata, 0);
    chk("rst_cnt", conflict_cnt, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    chk("rst_a_ready", a_ready, 1); chk("rst_b_ready", b_ready, 1);
    chk("rst_idle_m0_en", m0_en, 0); chk("rst_idle_m1_en", m1_en, 0);

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].av, tbl[i].bv, tbl[i].awe, tbl[i].bwe, tbl[i].aaddr, tbl[i].baddr,
            tbl[i].awd, tbl[i].bwd, tbl[i].cf);
      tick();
      chk($sformatf("v%0d_m0_en", i), m0_en, tbl[i].e0en);
      chk($sformatf("v%0d_m1_en", i), m1_en, tbl[i].e1en);
      chk($sformatf("v%0d_a_ready", i), a_ready, tbl[i].erdy);
      chk($sformatf("v%0d_b_ready", i), b_ready, tbl[i].erdy);
      chk($sformatf("v%0d_cnt", i), conflict_cnt, tbl[i].ecnt);
      if (tbl[i].e0en) begin
        chk($sformatf("v%0d_m0_we", i), m0_we, tbl[i].e0we);
        chk($sformatf("v%0d_m0_addr", i), m0_addr, tbl[i].e0addr);
        chk($sformatf("v%0d_m0_wdata", i), m0_wdata, tbl[i].e0wd);
      end
      if (tbl[i].e1en) begin
        chk($sformatf("v%0d_m1_we", i), m1_we, tbl[i].e1we);
        chk($sformatf("v%0d_m1_addr", i), m1_addr, tbl[i].e1addr);
        chk($sformatf("v%0d_m1_wdata", i), m1_wdata, tbl[i].e1wd);
      end
    end

    // Reset during DRAIN: pointer is at B here, so B wins and A is pending.
    drive(1, 1, 0, 1, 13'h001, 13'h002, 32'h11, 32'h22, 1);
    tick();
    chk("md_win_m1_en", m1_en, 1); chk("md_win_m0_en", m0_en, 0); chk("md_ready", a_ready, 0);
    rst_n = 1'b0;
    tick();
    chk("md_rst_m0_en", m0_en, 0); chk("md_rst_m1_en", m1_en, 0); chk("md_rst_cnt", conflict_cnt, 0);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("md_after_m0_en", m0_en, 0); chk("md_after_m1_en", m1_en, 0);
    drive(1, 1, 0, 1, 13'h001, 13'h002, 32'h11, 32'h22, 1);
    tick();
    chk("md_rr_m0_en", m0_en, 1); chk("md_rr_m1_en", m1_en, 0); chk("md_rr_cnt", conflict_cnt, 1);
    tick();
    chk("md_drain_m1_en", m1_en, 1); chk("md_drain_m1_addr", m1_addr, 13'h002);
    chk("md_drain_m0_en", m0_en, 0);

    // Counter saturation over 17 serialized pairs.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int p = 1; p <= 17; p++) begin
      drive(1, 1, 1, 1, 13'h040, 13'h041, p, p + 100, 1);
      tick();
      tick();
      chk($sformatf("sat_cnt_p%0d", p), conflict_cnt, (p > 15) ? 15 : p);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("sat_hold", conflict_cnt, 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
